// File: rtl/argon_alu_seq.sv
// Handshaked Argon ALU: single-cycle ops with a registered result, plus an optional
// iterative shift-add multiplier compiled in with ARGON_ALU_MUL_EN.
module argon_alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [7:0]       i_flags,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [7:0]       o_flags
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADC  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SBB  = 5'd3;
  localparam logic [4:0] ALU_CMP  = 5'd4;
  localparam logic [4:0] ALU_INC  = 5'd5;
  localparam logic [4:0] ALU_DEC  = 5'd6;
  localparam logic [4:0] ALU_NAND = 5'd7;
  localparam logic [4:0] ALU_AND  = 5'd8;
  localparam logic [4:0] ALU_OR   = 5'd9;
  localparam logic [4:0] ALU_NOR  = 5'd10;
  localparam logic [4:0] ALU_XOR  = 5'd11;
  localparam logic [4:0] ALU_LSH  = 5'd12;
  localparam logic [4:0] ALU_RSH  = 5'd13;
  localparam logic [4:0] ALU_ROL  = 5'd14;
  localparam logic [4:0] ALU_ROR  = 5'd15;

  localparam int unsigned F_CARRY   = 0;
  localparam int unsigned F_BORROW  = 1;
  localparam int unsigned F_ZERO    = 2;
  localparam int unsigned F_EQUAL   = 3;
  localparam int unsigned F_GREATER = 4;
  localparam int unsigned F_LESS    = 5;
  localparam int unsigned F_ERROR   = 6;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [7:0]       flags_q, flags_d;

  logic [WIDTH-1:0]   alu_y;
  logic [7:0]         alu_f;
  logic               alu_zf;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] rot;
  logic [SW-1:0]      shamt;
  logic               unused_flags;

  assign shamt        = i_b[SW-1:0];
  assign unused_flags = ^i_flags[7:2];

  // Single-cycle datapath, evaluated on the live request inputs at accept
  always_comb begin
    alu_y  = '0;
    alu_f  = '0;
    alu_zf = 1'b1;
    sum    = '0;
    rot    = '0;
    unique case (i_op)
      ALU_ADD, ALU_ADC: begin
        sum = {1'b0, i_a} + {1'b0, i_b}
            + (WIDTH+1)'((i_op == ALU_ADC) & i_flags[F_CARRY]);
        alu_y          = sum[WIDTH-1:0];
        alu_f[F_CARRY] = sum[WIDTH];
      end
      ALU_SUB, ALU_SBB: begin
        sum = {1'b0, i_a} - {1'b0, i_b}
            - (WIDTH+1)'((i_op == ALU_SBB) & i_flags[F_BORROW]);
        alu_y           = sum[WIDTH-1:0];
        alu_f[F_BORROW] = sum[WIDTH];
      end
      ALU_CMP: begin
        alu_zf           = 1'b0;
        alu_f[F_EQUAL]   = (i_a == i_b);
        alu_f[F_GREATER] = (i_a > i_b);
        alu_f[F_LESS]    = (i_a < i_b);
      end
      ALU_INC:  alu_y = i_a + WIDTH'(1);
      ALU_DEC:  alu_y = i_a - WIDTH'(1);
      ALU_NAND: alu_y = ~(i_a & i_b);
      ALU_AND:  alu_y = i_a & i_b;
      ALU_OR:   alu_y = i_a | i_b;
      ALU_NOR:  alu_y = ~(i_a | i_b);
      ALU_XOR:  alu_y = i_a ^ i_b;
      ALU_LSH:  alu_y = i_a << shamt;
      ALU_RSH:  alu_y = i_a >> shamt;
      ALU_ROL: begin
        rot   = {i_a, i_a} << shamt;
        alu_y = rot[2*WIDTH-1:WIDTH];
      end
      ALU_ROR: begin
        rot   = {i_a, i_a} >> shamt;
        alu_y = rot[WIDTH-1:0];
      end
      default: begin
        alu_zf         = 1'b0;
        alu_f[F_ERROR] = 1'b1;
      end
    endcase
    if (alu_zf) alu_f[F_ZERO] = (alu_y == '0);
  end

`ifdef ARGON_ALU_MUL_EN
  localparam int unsigned CW = SW + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic               mulh_q, mulh_d;
  logic [WIDTH-1:0]   mul_y;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      mulh_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      mulh_q   <= mulh_d;
    end
  end

  // Next state: single-cycle ops retire from IDLE; MUL/MULH iterate one bit per cycle in BUSY
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    mulh_d   = mulh_q;
    valid_d  = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;
    acc_step = '0;
    mul_y    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (i_op == 5'd16 || i_op == 5'd17) begin
            mcand_d  = {WIDTH'(0), i_a};
            mplier_d = i_b;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
            mulh_d   = i_op[0];
            state_d  = S_BUSY;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_y;
            flags_d  = alu_f;
          end
        end
      end
      S_BUSY: begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          mul_y            = mulh_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
          state_d          = S_IDLE;
          valid_d          = 1'b1;
          result_d         = mul_y;
          flags_d          = '0;
          flags_d[F_CARRY] = (acc_step[2*WIDTH-1:WIDTH] != '0);
          flags_d[F_ZERO]  = (mul_y == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ready = (state_q == S_IDLE);
`else
  always_comb begin
    valid_d  = i_valid;
    result_d = i_valid ? alu_y : result_q;
    flags_d  = i_valid ? alu_f : flags_q;
  end

  assign o_ready = 1'b1;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_argon_alu_seq.sv
// Directed self-checking bench for argon_alu_seq (WIDTH = 16); MUL sequences run when
// ARGON_ALU_MUL_EN is defined, otherwise opcode 16 is checked as undefined.
module tb_argon_alu_seq;

  localparam int unsigned W = 16;

  localparam logic [7:0] FC = 8'h01, FB = 8'h02, FZ = 8'h04, FE = 8'h08,
                         FG = 8'h10, FL = 8'h20, FR = 8'h40;

  logic         i_Clk = 1'b0;
  logic         i_Reset;
  logic         i_valid;
  logic         o_ready;
  logic [4:0]   i_op;
  logic [W-1:0] i_a, i_b;
  logic [7:0]   i_flags;
  logic         o_valid;
  logic [W-1:0] o_result;
  logic [7:0]   o_flags;

  int checks = 0;
  int errors = 0;

  argon_alu_seq #(.WIDTH(W)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_flags(i_flags),
    .o_valid(o_valid), .o_result(o_result), .o_flags(o_flags)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [7:0]   fin;
    logic [W-1:0] ey;
    logic [7:0]   ef;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [7:0] fin);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_flags = fin;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0;
    i_op    = 5'h1f;
    i_a     = '1;
    i_b     = '1;
    i_flags = 8'hff;
  endtask

  task automatic run_single(input int idx);
    @(negedge i_Clk);
    chk($sformatf("v%0d pre_valid", idx), 32'(o_valid), 32'd0);
    drive(vecs[idx].op, vecs[idx].a, vecs[idx].b, vecs[idx].fin);
    @(posedge i_Clk);
    #1;
    idle_inputs();
    chk($sformatf("v%0d valid", idx), 32'(o_valid), 32'd1);
    chk($sformatf("v%0d result", idx), 32'(o_result), 32'(vecs[idx].ey));
    chk($sformatf("v%0d flags", idx), 32'(o_flags), 32'(vecs[idx].ef));
    @(posedge i_Clk);
    #1;
    chk($sformatf("v%0d pulse_end", idx), 32'(o_valid), 32'd0);
    chk($sformatf("v%0d hold", idx), 32'(o_result), 32'(vecs[idx].ey));
  endtask

`ifdef ARGON_ALU_MUL_EN
  task automatic run_mul(input logic [4:0] op, input logic [W-1:0] ey, input logic [7:0] ef,
                         input bit poke, input string name);
    int cyc;
    int busy;
    @(negedge i_Clk);
    drive(op, 16'h1234, 16'h0100, 8'h00);
    @(posedge i_Clk);
    #1;
    idle_inputs();
    i_a  = 16'h0;
    cyc  = 0;
    busy = 0;
    while (!o_valid && cyc < 100) begin
      if (!o_ready) busy++;
      if (poke && cyc == 3) drive(5'd0, 16'h0001, 16'h0001, 8'h00);
      if (poke && cyc == 4) idle_inputs();
      @(posedge i_Clk);
      #1;
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(W));
    chk({name, " busy_cycles"}, 32'(busy), 32'(W));
    chk({name, " ready_at_valid"}, 32'(o_ready), 32'd1);
    chk({name, " result"}, 32'(o_result), 32'(ey));
    chk({name, " flags"}, 32'(o_flags), 32'(ef));
    @(posedge i_Clk);
    #1;
    chk({name, " no_extra_valid"}, 32'(o_valid), 32'd0);
  endtask
`endif

  initial begin
    vecs[0]  = '{5'd0,  16'hFFFF, 16'h0001, 8'h00, 16'h0000, FC | FZ};
    vecs[1]  = '{5'd3,  16'h0005, 16'h0005, FB,    16'hFFFF, FB};
    vecs[2]  = '{5'd1,  16'h7FFF, 16'h0000, FC,    16'h8000, 8'h00};
    vecs[3]  = '{5'd14, 16'h8001, 16'h0014, 8'h00, 16'h0018, 8'h00};
    vecs[4]  = '{5'd15, 16'h8001, 16'h0000, 8'h00, 16'h8001, 8'h00};
    vecs[5]  = '{5'h1F, 16'h1234, 16'h5678, 8'hFF, 16'h0000, FR};
    vecs[6]  = '{5'd2,  16'h0003, 16'h0005, FB,    16'hFFFE, FB};
    vecs[7]  = '{5'd4,  16'h0005, 16'h0003, 8'h00, 16'h0000, FG};
    vecs[8]  = '{5'd4,  16'h0003, 16'h0003, 8'h00, 16'h0000, FE};
    vecs[9]  = '{5'd4,  16'h0002, 16'h0003, 8'h00, 16'h0000, FL};
    vecs[10] = '{5'd5,  16'hFFFF, 16'h0000, 8'h00, 16'h0000, FZ};
    vecs[11] = '{5'd6,  16'h0000, 16'h0000, 8'h00, 16'hFFFF, 8'h00};
    vecs[12] = '{5'd8,  16'hF0F0, 16'h0FF0, 8'h00, 16'h00F0, 8'h00};
    vecs[13] = '{5'd7,  16'hFFFF, 16'hFFFF, 8'h00, 16'h0000, FZ};
    vecs[14] = '{5'd9,  16'h1200, 16'h0034, 8'h00, 16'h1234, 8'h00};
    vecs[15] = '{5'd10, 16'h0000, 16'h0000, 8'h00, 16'hFFFF, 8'h00};
    vecs[16] = '{5'd11, 16'hAAAA, 16'hAAAA, 8'h00, 16'h0000, FZ};
    vecs[17] = '{5'd12, 16'h0001, 16'h0013, 8'h00, 16'h0008, 8'h00};
    vecs[18] = '{5'd13, 16'h8000, 16'h000F, 8'h00, 16'h0001, 8'h00};
    vecs[19] = '{5'd0,  16'h0001, 16'h0001, FC,    16'h0002, 8'h00};
    vecs[20] = '{5'd15, 16'h0001, 16'h0001, 8'h00, 16'h8000, 8'h00};
    vecs[21] = '{5'd1,  16'hFFFF, 16'h0000, FC,    16'h0000, FC | FZ};
    vecs[22] = '{5'd3,  16'h0005, 16'h0004, FB,    16'h0000, FZ};
    vecs[23] = '{5'd2,  16'h0005, 16'h0005, FB,    16'h0000, FZ};

    idle_inputs();
    i_Reset = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1;
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_ready", 32'(o_ready), 32'd1);
    chk("reset o_result", 32'(o_result), 32'd0);
    chk("reset o_flags", 32'(o_flags), 32'd0);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    for (int i = 0; i < 24; i++) run_single(i);

    // three back-to-back ADDs retire on consecutive cycles
    @(negedge i_Clk);
    drive(5'd0, 16'h0010, 16'h0001, 8'h00);
    @(posedge i_Clk);
    #1;
    chk("b2b0 valid", 32'(o_valid), 32'd1);
    chk("b2b0 result", 32'(o_result), 32'h0011);
    drive(5'd0, 16'h0020, 16'h0002, 8'h00);
    @(posedge i_Clk);
    #1;
    chk("b2b1 valid", 32'(o_valid), 32'd1);
    chk("b2b1 result", 32'(o_result), 32'h0022);
    drive(5'd0, 16'hFFF0, 16'h0030, 8'h00);
    @(posedge i_Clk);
    #1;
    chk("b2b2 valid", 32'(o_valid), 32'd1);
    chk("b2b2 result", 32'(o_result), 32'h0020);
    chk("b2b2 flags", 32'(o_flags), 32'(FC));
    idle_inputs();
    @(posedge i_Clk);
    #1;
    chk("b2b end", 32'(o_valid), 32'd0);

`ifdef ARGON_ALU_MUL_EN
    run_mul(5'd16, 16'h3400, FC, 1'b1, "mul");
    run_mul(5'd17, 16'h0012, FC, 1'b0, "mulh");

    // reset during the 5th BUSY cycle discards the multiply
    @(negedge i_Clk);
    drive(5'd16, 16'h1234, 16'h0100, 8'h00);
    @(posedge i_Clk);
    #1;
    idle_inputs();
    repeat (4) @(posedge i_Clk);
    #1;
    chk("rst_busy ready_before", 32'(o_ready), 32'd0);
    i_Reset = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    chk("rst_busy o_ready", 32'(o_ready), 32'd1);
    chk("rst_busy o_valid", 32'(o_valid), 32'd0);
    chk("rst_busy o_result", 32'(o_result), 32'd0);
    chk("rst_busy o_flags", 32'(o_flags), 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < int'(W) + 4; k++) begin
        @(posedge i_Clk);
        #1;
        if (o_valid) seen++;
      end
      chk("rst_busy no_valid_after", 32'(seen), 32'd0);
    end
`else
    // without the multiplier, opcode 16 is undefined and single-cycle
    @(negedge i_Clk);
    drive(5'd16, 16'h1234, 16'h0100, 8'h00);
    @(posedge i_Clk);
    #1;
    idle_inputs();
    chk("nomul valid", 32'(o_valid), 32'd1);
    chk("nomul ready", 32'(o_ready), 32'd1);
    chk("nomul result", 32'(o_result), 32'd0);
    chk("nomul flags", 32'(o_flags), 32'(FR));
    @(posedge i_Clk);
    #1;
    chk("nomul pulse_end", 32'(o_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
